// File: rtl/dqn_fp_pkg.sv
// FP32 helpers shared by the DQN datapath: field widths, canonical quiet NaN,
// the total-order key used for max selection, the NaN test and the selector FSM encoding.
// Purely declarative: no latency, no flow control.
package dqn_fp_pkg;

    localparam int FP32_WIDTH      = 32;
    localparam int FP32_EXP_WIDTH  = 8;
    localparam int FP32_MANT_WIDTH = 23;

    localparam logic [FP32_WIDTH-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCAN    = 2'd2
    } sel_state_t;

    // Maps IEEE-754 bits onto an unsigned integer whose order matches the
    // numeric order: negatives are bit-inverted (bigger magnitude -> smaller key),
    // positives get the sign bit set so they land above every negative.
    function automatic logic [FP32_WIDTH-1:0] fp32_order_key(input logic [FP32_WIDTH-1:0] x);
        return x[FP32_WIDTH-1] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    function automatic logic fp32_is_nan(input logic [FP32_WIDTH-1:0] x);
        return (x[FP32_MANT_WIDTH +: FP32_EXP_WIDTH] == '1) &&
               (x[FP32_MANT_WIDTH-1:0] != '0);
    endfunction

endpackage

// File: rtl/fp32_compare_gt.sv
// Purpose: combinational FP32 strict greater-than on the total-order key.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
// Ports: a, b (FP32 operands) -> a_gt_b (1 when a ranks strictly above b).
// Build option MAX_Q_SELECTOR_NAN_FILTER_EN: a NaN never ranks above a non-NaN,
// and a non-NaN always ranks above a NaN; two NaNs compare as not-greater.
module fp32_compare_gt
    import dqn_fp_pkg::*;
(
    input  logic [FP32_WIDTH-1:0] a,
    input  logic [FP32_WIDTH-1:0] b,
    output logic                  a_gt_b
);

`ifdef MAX_Q_SELECTOR_NAN_FILTER_EN
    logic a_nan;
    logic b_nan;

    assign a_nan = fp32_is_nan(a);
    assign b_nan = fp32_is_nan(b);

    always_comb begin
        a_gt_b = 1'b0;
        if (a_nan) begin
            a_gt_b = 1'b0;
        end else if (b_nan) begin
            // lets the first real value displace a NaN seed
            a_gt_b = 1'b1;
        end else begin
            a_gt_b = fp32_order_key(a) > fp32_order_key(b);
        end
    end
`else
    assign a_gt_b = fp32_order_key(a) > fp32_order_key(b);
`endif

endmodule

// File: rtl/max_q_selector.sv
// Purpose: capture one FP32 Q-value per action node, then scan sequentially for the max Q and its index.
// Latency: last node captured at edge E -> o_valid high in the cycle after edge E+NUMBER_OF_ACTION-1.
// Backpressure: none; inputs arriving during SCAN are dropped and flagged on sticky o_overrun.
// Ports: clk, rst_n (sync, active-low); i_valid/i_data per-node strobes and packed Q-values;
//        o_data/o_index hold the latest result, o_valid one-cycle strobe, o_busy while scanning.
// Build option MAX_Q_SELECTOR_NAN_FILTER_EN: NaNs never win; an all-NaN batch yields 7FC0_0000 at index 0.
module max_q_selector
    import dqn_fp_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int NUMBER_OF_ACTION = 3,
    parameter int INDEX_WIDTH      = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUMBER_OF_ACTION-1:0]            i_valid,
    input  logic [NUMBER_OF_ACTION*DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0]                  o_data,
    output logic [INDEX_WIDTH-1:0]                 o_index,
    output logic                                   o_valid,
    output logic                                   o_busy,
    output logic                                   o_overrun
);

    localparam logic [NUMBER_OF_ACTION-1:0] ALL_ONES = '1;
    localparam logic [INDEX_WIDTH-1:0]      LAST_IDX = INDEX_WIDTH'(NUMBER_OF_ACTION - 1);

    sel_state_t state;
    sel_state_t state_nxt;

    logic [DATA_WIDTH-1:0]       q [NUMBER_OF_ACTION];
    logic [NUMBER_OF_ACTION-1:0] mask;
    logic [NUMBER_OF_ACTION-1:0] mask_all;
    logic [INDEX_WIDTH-1:0]      scan_idx;
    logic [INDEX_WIDTH-1:0]      best_idx;
    logic [DATA_WIDTH-1:0]       best;
    logic [DATA_WIDTH-1:0]       seed;
    logic [DATA_WIDTH-1:0]       cand;
    logic                        cand_gt;
    logic [DATA_WIDTH-1:0]       winner;
    logic [INDEX_WIDTH-1:0]      winner_idx;

    assign mask_all = mask | i_valid;

    // q[0] may be arriving on the very edge that completes the batch,
    // so the seed has to bypass the register file.
    assign seed = i_valid[0] ? i_data[DATA_WIDTH-1:0] : q[0];
    assign cand = q[scan_idx];

    fp32_compare_gt u_cmp (
        .a      (cand),
        .b      (best),
        .a_gt_b (cand_gt)
    );

    // Outcome of the compare happening this cycle; used on the final scan step
    // so the result lands on the same edge as the last compare.
    always_comb begin
        winner     = best;
        winner_idx = best_idx;
        if (cand_gt) begin
            winner     = cand;
            winner_idx = scan_idx;
        end
`ifdef MAX_Q_SELECTOR_NAN_FILTER_EN
        // a NaN can only survive the scan when every entry was NaN
        if (fp32_is_nan(winner)) begin
            winner     = FP32_QNAN;
            winner_idx = '0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, COLLECT: begin
                if (mask_all == ALL_ONES) begin
                    state_nxt = SCAN;
                end else if (mask_all != '0) begin
                    state_nxt = COLLECT;
                end
            end
            SCAN: begin
                if (scan_idx == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '0;
            scan_idx  <= '0;
            best_idx  <= '0;
            best      <= '0;
            o_data    <= '0;
            o_index   <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
            for (int k = 0; k < NUMBER_OF_ACTION; k++) begin
                q[k] <= '0;
            end
        end else begin
            state   <= state_nxt;
            o_valid <= 1'b0;
            o_busy  <= (state_nxt == SCAN);
            unique case (state)
                IDLE, COLLECT: begin
                    for (int k = 0; k < NUMBER_OF_ACTION; k++) begin
                        if (i_valid[k]) begin
                            q[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    mask <= mask_all;
                    if (state_nxt == SCAN) begin
                        best     <= seed;
                        best_idx <= '0;
                        scan_idx <= INDEX_WIDTH'(1);
                    end
                end
                SCAN: begin
                    if (i_valid != '0) begin
                        o_overrun <= 1'b1;
                    end
                    if (cand_gt) begin
                        best     <= cand;
                        best_idx <= scan_idx;
                    end
                    scan_idx <= scan_idx + INDEX_WIDTH'(1);
                    if (scan_idx == LAST_IDX) begin
                        o_data  <= winner;
                        o_index <= winner_idx;
                        o_valid <= 1'b1;
                        mask    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_max_q_selector.sv
// Purpose: self-checking bench for max_q_selector (N=3) with a reference model and directed vectors.
// Latency: model predicts o_valid NUMBER_OF_ACTION-1 edges after the completing capture edge.
// Backpressure: none; overrun during SCAN is exercised and checked.
module tb_max_q_selector;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    i_valid;
    logic [N*DW-1:0] i_data;
    logic [DW-1:0]   o_data;
    logic [IW-1:0]   o_index;
    logic            o_valid;
    logic            o_busy;
    logic            o_overrun;

    int n_chk  = 0;
    int n_fail = 0;

    max_q_selector #(
        .DATA_WIDTH       (DW),
        .NUMBER_OF_ACTION (N),
        .INDEX_WIDTH      (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_data    (o_data),
        .o_index   (o_index),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Numeric ranking from sign and magnitude: any positive (incl. +0) outranks
    // any negative; among positives bigger magnitude wins; among negatives smaller wins.
    function automatic bit ranks_above(input logic [31:0] a, input logic [31:0] b);
        bit na, nb;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
`ifdef MAX_Q_SELECTOR_NAN_FILTER_EN
        if (na) return 0;
        if (nb) return 1;
`endif
        if (a[31] != b[31]) return !a[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    logic [31:0] mq [N];
    bit   [N-1:0] mmask;
    int          cd;
    logic [31:0] pend_d;
    int          pend_i;
    logic [31:0] exp_data;
    int          exp_idx;
    bit          exp_valid, exp_busy, exp_ovr;

    always @(posedge clk) begin
        if (!rst_n) begin
            mmask = 0; cd = 0;
            exp_valid = 0; exp_busy = 0; exp_ovr = 0;
            exp_data = 0; exp_idx = 0;
        end else begin
            exp_valid = 0;
            if (cd > 0) begin
                if (i_valid != 0) exp_ovr = 1;
                cd--;
                if (cd == 0) begin
                    exp_valid = 1; exp_busy = 0;
                    exp_data = pend_d; exp_idx = pend_i;
                    mmask = 0;
                end
            end else begin
                for (int k = 0; k < N; k++)
                    if (i_valid[k]) mq[k] = i_data[k*DW +: DW];
                mmask = mmask | i_valid;
                if (mmask == '1) begin
                    pend_d = mq[0]; pend_i = 0;
                    for (int k = 1; k < N; k++)
                        if (ranks_above(mq[k], pend_d)) begin
                            pend_d = mq[k]; pend_i = k;
                        end
`ifdef MAX_Q_SELECTOR_NAN_FILTER_EN
                    if ((pend_d[30:23] == 8'hFF) && (pend_d[22:0] != 0)) begin
                        pend_d = 32'h7FC0_0000; pend_i = 0;
                    end
`endif
                    cd = N - 1;
                    exp_busy = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("o_valid",   {31'd0, o_valid},   {31'd0, exp_valid});
        check("o_busy",    {31'd0, o_busy},    {31'd0, exp_busy});
        check("o_overrun", {31'd0, o_overrun}, {31'd0, exp_ovr});
        check("o_data",    o_data,             exp_data);
        check("o_index",   {30'd0, o_index},   exp_idx);
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+2: presents inputs for exactly one capture edge.
    task automatic pulse(input logic [N-1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
        i_valid = v;
        i_data  = {d2, d1, d0};
        @(posedge clk); #2;
        i_valid = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
        end
    endtask

    // Waits (bounded) for o_valid and pins the result against hand-computed literals.
    task automatic wait_result(input string nm, input logic [31:0] d, input int idx, input int lat);
        int cnt;
        bit seen;
        cnt = 0; seen = 0;
        while (!seen && cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (o_valid) seen = 1;
        end
        check({nm, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({nm, "_data"},  o_data,           d);
            check({nm, "_index"}, {30'd0, o_index}, idx);
            check({nm, "_model"}, exp_data,         d);
            if (lat > 0) check({nm, "_latency"}, cnt, lat);
        end
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = '0;
        i_data  = '0;
        idle(2);
        check("reset_data",  o_data,               32'h0);
        check("reset_valid", {31'd0, o_valid},     32'h0);
        check("reset_busy",  {31'd0, o_busy},      32'h0);
        check("reset_ovr",   {31'd0, o_overrun},   32'h0);
        rst_n = 1'b1;
        idle(1);

        // 1: all valid together; result on the 3rd negedge after the capture edge
        pulse(3'b111, 32'h3F80_0000, 32'h4020_0000, 32'hC040_0000);
        wait_result("t1", 32'h4020_0000, 1, 3);
        idle(2);

        // 2: all negative
        pulse(3'b111, 32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000);
        wait_result("t2", 32'hBF00_0000, 1, 3);
        idle(1);

        // 3: tie -> lowest index; +0 beats -0
        pulse(3'b111, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000);
        wait_result("t3a", 32'h4000_0000, 0, 3);
        idle(1);
        pulse(3'b111, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
        wait_result("t3b", 32'h0000_0000, 1, 3);
        idle(1);

        // 4: staggered arrival with an overwrite of node 0
        pulse(3'b100, 32'h0, 32'h0, 32'h4080_0000);            // t0
        idle(2);
        pulse(3'b001, 32'h3F80_0000, 32'h0, 32'h0);            // t3
        check("t4_busy_collect", {31'd0, o_busy}, 32'h0);
        pulse(3'b001, 32'h4100_0000, 32'h0, 32'h0);            // t4
        pulse(3'b010, 32'h0, 32'h4000_0000, 32'h0);            // t5
        wait_result("t4", 32'h4100_0000, 0, 3);
        idle(1);

        // 5: inputs during SCAN are dropped and flagged
        pulse(3'b111, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000);
        pulse(3'b111, 32'h4700_0000, 32'h4700_0000, 32'h4700_0000);
        wait_result("t5", 32'h3F40_0000, 2, 0);
        idle(4);
        check("t5_overrun_sticky", {31'd0, o_overrun}, 32'h1);
        check("t5_no_second", o_data, 32'h3F40_0000);

        // 6: reset for one cycle mid-SCAN aborts the batch
        pulse(3'b111, 32'h4000_0000, 32'h4100_0000, 32'h4200_0000);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("t6_data",    o_data,             32'h0);
        check("t6_index",   {30'd0, o_index},   32'h0);
        check("t6_busy",    {31'd0, o_busy},    32'h0);
        check("t6_overrun", {31'd0, o_overrun}, 32'h0);
        idle(4);
        check("t6_no_valid_data", o_data, 32'h0);
        // capture mask was cleared: a single node must not start a scan
        pulse(3'b001, 32'h3F80_0000, 32'h0, 32'h0);
        idle(1);
        check("t6_mask_clear", {31'd0, o_busy}, 32'h0);
        pulse(3'b110, 32'h0, 32'h3F00_0000, 32'hBF80_0000);
        wait_result("t6b", 32'h3F80_0000, 0, 3);
        idle(1);

        // 7: NaN handling
`ifdef MAX_Q_SELECTOR_NAN_FILTER_EN
        pulse(3'b111, 32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0001);
        wait_result("t7_filter", 32'h3F80_0000, 1, 3);
        idle(1);
        pulse(3'b111, 32'hFFC0_0000, 32'h7F80_0001, 32'h7FC0_0001);
        wait_result("t7_allnan", 32'h7FC0_0000, 0, 3);
`else
        pulse(3'b111, 32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0001);
        wait_result("t7_raw", 32'h7FC0_0000, 0, 3);
        idle(1);
        pulse(3'b111, 32'hFFC0_0000, 32'hFF80_0000, 32'h7F80_0000);
        wait_result("t7_raw_neg", 32'h7F80_0000, 2, 3);
`endif
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
